// File: rtl/uart_line_fifo.sv
// Line-buffered byte FIFO between the UART receive and transmit handshakes.
// Bytes are held until a CR/LF commits the line; BS/DEL edit the open line.
module uart_line_fifo #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              line_done,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic del;
    logic term;
  } byte_cls_t;

  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, cm_ptr, rd_ptr;
  logic [ADDR_W:0] wr_inc;
  byte_cls_t       cls;
  logic            full, acc, store, erase, commit, rd_en;

  always_comb begin
    cls      = '0;
    cls.del  = (in_data == 8'h08) || (in_data == 8'h7F);
    cls.term = (in_data == 8'h0D) || (in_data == 8'h0A);
  end

  // Status is derived only from registered pointers, so no input reaches an output.
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == FULL_LVL);
  assign in_ready = !full;

  assign acc    = in_valid && in_ready;
  assign store  = acc && !cls.del;
  assign erase  = acc && cls.del && (wr_ptr != cm_ptr);
  assign wr_inc = wr_ptr + 1'b1;
  // A line that fills the buffer is committed anyway so the buffer can drain.
  assign commit = store && (cls.term || ((wr_inc - rd_ptr) == FULL_LVL));

  assign out_valid = (rd_ptr != cm_ptr);
  assign out_data  = mem[rd_ptr[ADDR_W-1:0]];
  assign rd_en     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr[ADDR_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      rd_ptr    <= '0;
      line_done <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (store)      wr_ptr <= wr_inc;
      else if (erase) wr_ptr <= wr_ptr - 1'b1;
      if (commit)     cm_ptr <= wr_inc;
      if (rd_en)      rd_ptr <= rd_ptr + 1'b1;
      line_done <= commit;
      if (in_valid && !in_ready) overflow <= 1'b1;
      else if (clr_ovf)          overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_line_fifo.sv
// Directed bench for uart_line_fifo with a queue-based line model checked every cycle.
module tb_uart_line_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] level;
  logic       line_done;
  logic       overflow;
  logic       clr_ovf;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] cq[$];
  logic [7:0] lq[$];
  logic [7:0] got_b[$];
  int         got_c[$];
  bit         ovf_m, exp_ld;

  uart_line_fifo #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .line_done(line_done), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: committed queue cq and open line lq, advanced at each falling edge
  // from the inputs that the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      cq.delete(); lq.delete();
      ovf_m  = 1'b0;
      exp_ld = 1'b0;
    end else begin
      int lvl0;
      lvl0 = cq.size() + lq.size();
      chk("mon_level",     int'(level),     lvl0);
      chk("mon_in_ready",  int'(in_ready),  int'(lvl0 != 64));
      chk("mon_out_valid", int'(out_valid), int'(cq.size() != 0));
      chk("mon_line_done", int'(line_done), int'(exp_ld));
      chk("mon_overflow",  int'(overflow),  int'(ovf_m));
      exp_ld = 1'b0;
      if (out_valid && out_ready && cq.size() != 0) begin
        chk("mon_out_data", int'(out_data), int'(cq[0]));
        got_b.push_back(out_data);
        got_c.push_back(cyc);
        void'(cq.pop_front());
      end
      if (in_valid && lvl0 == 64) ovf_m = 1'b1;
      else if (clr_ovf)           ovf_m = 1'b0;
      if (in_valid && lvl0 != 64) begin
        if (in_data == 8'h08 || in_data == 8'h7F) begin
          if (lq.size() != 0) void'(lq.pop_back());
        end else begin
          lq.push_back(in_data);
          if (in_data == 8'h0D || in_data == 8'h0A || lvl0 + 1 == 64) begin
            foreach (lq[i]) cq.push_back(lq[i]);
            lq.delete();
            exp_ld = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Offers a byte only once in_ready is high, with random idle gaps and read throttling.
  task automatic send_rdy(input logic [7:0] b);
    int g;
    g = 0;
    while (!in_ready && g < 500) begin
      out_ready = 1'b1;
      tick();
      g++;
    end
    if (g == 500) chk("in_ready_wait", int'(in_ready), 1);
    if ($urandom_range(0, 2) == 0) begin
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = ($urandom_range(0, 3) != 0);
    send(b);
  endtask

  initial begin
    logic [7:0] b;
    int len;
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_level",     int'(level),     0);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_line_done", int'(line_done), 0);
    chk("rst_overflow",  int'(overflow),  0);

    // Line release
    got_b.delete(); got_c.delete();
    send(8'h61); send(8'h62);
    chk("rel_hold_valid", int'(out_valid), 0);
    chk("rel_hold_level", int'(level), 2);
    send(8'h0D);
    chk("rel_commit_valid", int'(out_valid), 1);
    chk("rel_line_done",    int'(line_done), 1);
    tick();
    chk("rel_line_done_end", int'(line_done), 0);
    repeat (4) tick();
    chk("rel_count", got_b.size(), 3);
    if (got_b.size() == 3) begin
      chk("rel_b0", int'(got_b[0]), 'h61);
      chk("rel_b1", int'(got_b[1]), 'h62);
      chk("rel_b2", int'(got_b[2]), 'h0D);
      chk("rel_consec0", got_c[1] - got_c[0], 1);
      chk("rel_consec1", got_c[2] - got_c[1], 1);
    end
    chk("rel_level_end", int'(level), 0);

    // Line editing
    got_b.delete(); got_c.delete();
    send(8'h61); send(8'h62);
    chk("edit_level_peak", int'(level), 2);
    send(8'h08);
    chk("edit_level_bs", int'(level), 1);
    send(8'h63);
    chk("edit_level_peak2", int'(level), 2);
    send(8'h0A);
    repeat (4) tick();
    chk("edit_count", got_b.size(), 3);
    if (got_b.size() == 3) begin
      chk("edit_b0", int'(got_b[0]), 'h61);
      chk("edit_b1", int'(got_b[1]), 'h63);
      chk("edit_b2", int'(got_b[2]), 'h0A);
    end

    // Deletes on an empty line are discarded
    got_b.delete(); got_c.delete();
    send(8'h7F);
    chk("bs_empty_level", int'(level), 0);
    send(8'h08);
    chk("bs_empty_level2", int'(level), 0);
    send(8'h78); send(8'h0D);
    repeat (4) tick();
    chk("bs_count", got_b.size(), 2);
    if (got_b.size() == 2) begin
      chk("bs_b0", int'(got_b[0]), 'h78);
      chk("bs_b1", int'(got_b[1]), 'h0D);
    end

    // Fill with no terminator; data bytes 0x20..0x5F stay clear of BS/CR/LF codes
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) send(8'(32 + i));
    chk("fill_line_done", int'(line_done), 1);
    chk("fill_level",     int'(level), 64);
    chk("fill_in_ready",  int'(in_ready), 0);
    chk("fill_out_valid", int'(out_valid), 1);
    // Write while full alongside a read: write refused, slot freed for later
    got_b.delete(); got_c.delete();
    out_ready = 1'b1;
    send(8'h60);
    chk("fill_overflow",  int'(overflow), 1);
    chk("fill_level_rd",  int'(level), 63);
    chk("fill_in_ready2", int'(in_ready), 1);
    repeat (70) tick();
    chk("drain_count", got_b.size(), 64);
    if (got_b.size() == 64)
      for (int i = 0; i < 64; i++) chk("drain_byte", int'(got_b[i]), 32 + i);
    chk("drain_level", int'(level), 0);
    chk("ovf_sticky", int'(overflow), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clear", int'(overflow), 0);

    // Pointer wrap under random traffic; the model checks every byte and level
    for (int ln = 0; ln < 200; ln++) begin
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++) begin
        if (k == len - 1)                  b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
        else if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
        else                               b = 8'($urandom_range(32, 126));
        send_rdy(b);
      end
    end
    out_ready = 1'b1;
    repeat (80) tick();
    chk("wrap_level", int'(level), 0);
    chk("wrap_out_valid", int'(out_valid), 0);

    // Reset mid-line
    out_ready = 1'b0;
    send(8'h61); send(8'h62); send(8'h63); send(8'h64); send(8'h0A);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    send(8'h71); send(8'h72); send(8'h73);
    chk("mid_level", int'(level), 6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();
    got_b.delete(); got_c.delete();
    out_ready = 1'b1;
    send(8'h7A); send(8'h0A);
    repeat (4) tick();
    chk("post_rst_count", got_b.size(), 2);
    if (got_b.size() == 2) begin
      chk("post_rst_b0", int'(got_b[0]), 'h7A);
      chk("post_rst_b1", int'(got_b[1]), 'h0A);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
